axis_delay_scan: RTL and testbench

Alignment controller for the AXI-Stream delay line. It sweeps the delay setting from 0 to MAX_DELAY and, at each setting, compares the delayed stream against a reference stream for a fixed number of accepted beats. It then programs the centre of the longest error-free window of settings. It sits beside the delay line in the `clk` domain and drives the delay value that the integration muxes in ahead of the register-programmed value.

---
 rtl/axis_delay_pkg.sv | 23 ++
 rtl/axis_delay_window_track.sv | 73 +++++++
 rtl/axis_delay_scan.sv | 186 ++++++++++++++++++
 tb/tb_axis_delay_scan.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_delay_pkg.sv
// Shared types and defaults for the AXI-Stream delay-line alignment scan.
package axis_delay_pkg;

    localparam int DELAY_WIDTH_DEF = 6;
    localparam int MAX_DELAY_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET     = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        EVAL    = 3'd4,
        FINISH  = 3'd5
    } scan_state_t;

    // Beat counter must reach the larger of the two beat budgets.
    function automatic int beat_cnt_width(input int settle_beats, input int dwell_beats);
        int top;
        top = (settle_beats > dwell_beats) ? settle_beats : dwell_beats;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/axis_delay_window_track.sv
// Tracks the current run of good delay settings and the longest run seen so far.
module axis_delay_window_track
    import axis_delay_pkg::*;
#(
    parameter int DELAY_WIDTH = DELAY_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   eval_i,
    input  logic                   good_i,
    input  logic [DELAY_WIDTH-1:0] cur_i,
    output logic [DELAY_WIDTH-1:0] best_start_o,
    output logic [DELAY_WIDTH:0]   best_len_o
);

    logic [DELAY_WIDTH-1:0] run_start_q, run_start_d;
    logic [DELAY_WIDTH:0]   run_len_q, run_len_d;
    logic [DELAY_WIDTH-1:0] best_start_q, best_start_d;
    logic [DELAY_WIDTH:0]   best_len_q, best_len_d;

    // Extend or break the current run and promote it only when strictly longer.
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear_i) begin
            run_start_d  = {DELAY_WIDTH{1'b0}};
            run_len_d    = {(DELAY_WIDTH+1){1'b0}};
            best_start_d = {DELAY_WIDTH{1'b0}};
            best_len_d   = {(DELAY_WIDTH+1){1'b0}};
        end else if (eval_i) begin
            if (good_i) begin
                if (run_len_q == {(DELAY_WIDTH+1){1'b0}}) begin
                    run_start_d = cur_i;
                end else begin
                    run_start_d = run_start_q;
                end
                run_len_d = run_len_q + {{DELAY_WIDTH{1'b0}}, 1'b1};
            end else begin
                run_len_d = {(DELAY_WIDTH+1){1'b0}};
            end
            if (run_len_d > best_len_q) begin
                best_start_d = run_start_d;
                best_len_d   = run_len_d;
            end else begin
                best_len_d   = best_len_q;
            end
        end else begin
            run_len_d = run_len_q;
        end
    end

    // Window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_start_q  <= {DELAY_WIDTH{1'b0}};
            run_len_q    <= {(DELAY_WIDTH+1){1'b0}};
            best_start_q <= {DELAY_WIDTH{1'b0}};
            best_len_q   <= {(DELAY_WIDTH+1){1'b0}};
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/axis_delay_scan.sv
// Delay-line alignment controller: sweeps every delay setting, scores each against
// the reference stream, then programs the centre of the longest error-free window.
module axis_delay_scan
    import axis_delay_pkg::*;
#(
    parameter int TDATA_WIDTH  = 32,
    parameter int DELAY_WIDTH  = DELAY_WIDTH_DEF,
    parameter int MAX_DELAY    = MAX_DELAY_DEF,
    parameter int SETTLE_BEATS = 32,
    parameter int DWELL_BEATS  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [TDATA_WIDTH-1:0] mon_tdata,
    input  logic [TDATA_WIDTH-1:0] ref_tdata,
    input  logic                   mon_beat,
    output logic [DELAY_WIDTH-1:0] delay_out,
    output logic                   delay_update,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [DELAY_WIDTH-1:0] best_start,
    output logic [DELAY_WIDTH:0]   best_len
);

    localparam int BCW = beat_cnt_width(SETTLE_BEATS, DWELL_BEATS);
    localparam logic [BCW-1:0]         SETTLE_LAST = BCW'(SETTLE_BEATS - 1);
    localparam logic [BCW-1:0]         DWELL_LAST  = BCW'(DWELL_BEATS - 1);
    localparam logic [DELAY_WIDTH-1:0] MAX_D       = DELAY_WIDTH'(MAX_DELAY);

    scan_state_t            state_q, state_d;
    logic [DELAY_WIDTH-1:0] cur_q, cur_d;
    logic [BCW-1:0]         cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic                   upd_q, upd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q, fail_d;

    logic                   trk_clear_s;
    logic                   trk_eval_s;
    logic                   mismatch_s;
    logic [DELAY_WIDTH-1:0] best_start_s;
    logic [DELAY_WIDTH:0]   best_len_s;
    logic [DELAY_WIDTH:0]   half_len_s;
    logic [DELAY_WIDTH-1:0] centre_s;

    assign mismatch_s = (mon_tdata != ref_tdata);
    assign half_len_s = best_len_s >> 1;
    // Half of a window never exceeds the delay range, so the truncation is lossless.
    assign centre_s   = best_start_s + half_len_s[DELAY_WIDTH-1:0];

    axis_delay_window_track #(
        .DELAY_WIDTH (DELAY_WIDTH)
    ) u_track (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (trk_clear_s),
        .eval_i       (trk_eval_s),
        .good_i       (~err_q),
        .cur_i        (cur_q),
        .best_start_o (best_start_s),
        .best_len_o   (best_len_s)
    );

    // Scan sequencing, beat counting and result programming.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        delay_d     = delay_q;
        upd_d       = 1'b0;
        done_d      = done_q;
        fail_d      = fail_q;
        trk_clear_s = 1'b0;
        trk_eval_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SET;
                    cur_d       = {DELAY_WIDTH{1'b0}};
                    cnt_d       = {BCW{1'b0}};
                    err_d       = 1'b0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    trk_clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SET: begin
                delay_d = cur_q;
                upd_d   = 1'b1;
                cnt_d   = {BCW{1'b0}};
                err_d   = 1'b0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (mon_beat) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = {BCW{1'b0}};
                        state_d = MEASURE;
                    end else begin
                        cnt_d = cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            MEASURE: begin
                if (mon_beat) begin
                    err_d = err_q | mismatch_s;
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = {BCW{1'b0}};
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            EVAL: begin
                trk_eval_s = 1'b1;
                if (cur_q == MAX_D) begin
                    state_d = FINISH;
                end else begin
                    cur_d   = cur_q + {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
                    state_d = SET;
                end
            end
            FINISH: begin
                if (best_len_s != {(DELAY_WIDTH+1){1'b0}}) begin
                    delay_d = centre_s;
                end else begin
                    delay_d = {DELAY_WIDTH{1'b0}};
                    fail_d  = 1'b1;
                end
                upd_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Controller state and registered outputs; reset aborts any scan in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= {DELAY_WIDTH{1'b0}};
            cnt_q   <= {BCW{1'b0}};
            err_q   <= 1'b0;
            delay_q <= {DELAY_WIDTH{1'b0}};
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            delay_q <= delay_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign delay_out    = delay_q;
    assign delay_update = upd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign best_start   = best_start_s;
    assign best_len     = best_len_s;

endmodule

// File: tb/tb_axis_delay_scan.sv
// Directed bench for axis_delay_scan: a modelled delay line whose output matches the
// reference only for chosen settings, with hand-computed scan results and timing.
module tb_axis_delay_scan;

    localparam int TW = 32;
    localparam int DW = 6;
    localparam int MAXD = 32;
    localparam int SB = 4;
    localparam int DB = 8;
    localparam int NOMINAL = (MAXD + 1) * (1 + SB + DB + 1) + 2;
    localparam int TIMEOUT = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] mon_tdata;
    logic [TW-1:0] ref_tdata;
    logic          mon_beat;
    logic [DW-1:0] delay_out;
    logic          delay_update;
    logic          busy;
    logic          done;
    logic          fail;
    logic [DW-1:0] best_start;
    logic [DW:0]   best_len;

    logic [63:0]   good_mask = 64'd0;
    logic          slow_beats = 1'b0;
    logic [TW-1:0] ref_word = 32'h1234_5678;
    logic [1:0]    phase = 2'd0;

    int checks = 0;
    int errors = 0;

    axis_delay_scan #(
        .TDATA_WIDTH  (TW),
        .DELAY_WIDTH  (DW),
        .MAX_DELAY    (MAXD),
        .SETTLE_BEATS (SB),
        .DWELL_BEATS  (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mon_tdata    (mon_tdata),
        .ref_tdata    (ref_tdata),
        .mon_beat     (mon_beat),
        .delay_out    (delay_out),
        .delay_update (delay_update),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .best_start   (best_start),
        .best_len     (best_len)
    );

    always #5 clk = ~clk;

    // Reference stream and beat cadence advance every clock.
    always @(posedge clk) begin
        ref_word <= ref_word * 32'd1103515245 + 32'd12345;
        phase    <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
    end

    assign ref_tdata = ref_word;
    assign mon_tdata = good_mask[delay_out] ? ref_word : ~ref_word;
    assign mon_beat  = slow_beats ? (phase == 2'd0) : 1'b1;

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic run_scan(input logic [63:0] mask, input int poke_at,
                            output int cycles, output int pulses,
                            output int first_upd, output logic [DW-1:0] first_delay,
                            output logic busy_after_start);
        good_mask = mask;
        pulses = 0;
        first_upd = -1;
        first_delay = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        busy_after_start = busy;
        while (!done && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            start = (cycles == poke_at);
            if (delay_update) begin
                pulses++;
                if (first_upd < 0) begin
                    first_upd = cycles;
                    first_delay = delay_out;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({delay_out, delay_update, busy, done, fail, best_start, best_len} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required 0",
                     {delay_out, delay_update, busy, done, fail, best_start, best_len});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({delay_out, delay_update, busy, done, fail, best_start, best_len} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h required 0",
                     {delay_out, delay_update, busy, done, fail, best_start, best_len});
        end
    endtask

    task automatic test_reset_mid_scan;
        int n;
        good_mask = range_mask(2, 4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(delay_update && delay_out == 6'd5) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= TIMEOUT) begin
            errors++;
            $display("FAIL midscan_reach5: timeout after %0d cycles, required setting 5", n);
        end
        repeat (SB + 2) @(negedge clk);
        checks++;
        if (best_start !== 6'd2 || best_len !== 7'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midscan_pre: best_start=%0d best_len=%0d busy=%b required 2 3 1",
                     best_start, best_len, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({delay_out, delay_update, busy, done, fail, best_start, best_len} !== '0) begin
            errors++;
            $display("FAIL midscan_reset: outputs=%h required 0",
                     {delay_out, delay_update, busy, done, fail, best_start, best_len});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midscan_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_main_window;
        int cyc, pul, fu;
        logic [DW-1:0] fd;
        logic b;
        run_scan(range_mask(10, 14), -1, cyc, pul, fu, fd, b);
        checks++;
        if (b !== 1'b1 || fu != 2 || fd !== 6'd0) begin
            errors++;
            $display("FAIL main_start_timing: busy=%b first_upd=%0d first_delay=%0d required 1 2 0",
                     b, fu, fd);
        end
        checks++;
        if (best_start !== 6'd10 || best_len !== 7'd5 || delay_out !== 6'd12) begin
            errors++;
            $display("FAIL main_result: start=%0d len=%0d delay=%0d required 10 5 12",
                     best_start, best_len, delay_out);
        end
        checks++;
        if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || delay_update !== 1'b1) begin
            errors++;
            $display("FAIL main_flags: done=%b fail=%b busy=%b upd=%b required 1 0 0 1",
                     done, fail, busy, delay_update);
        end
        checks++;
        if (cyc != NOMINAL || pul != MAXD + 2) begin
            errors++;
            $display("FAIL main_timing: cycles=%0d pulses=%0d required %0d %0d",
                     cyc, pul, NOMINAL, MAXD + 2);
        end
        @(negedge clk);
        checks++;
        if (delay_update !== 1'b0 || done !== 1'b1 || delay_out !== 6'd12) begin
            errors++;
            $display("FAIL main_after: upd=%b done=%b delay=%0d required 0 1 12",
                     delay_update, done, delay_out);
        end
    endtask

    task automatic test_tie;
        int cyc, pul, fu;
        logic [DW-1:0] fd;
        logic b;
        run_scan(range_mask(3, 5) | range_mask(20, 22), -1, cyc, pul, fu, fd, b);
        checks++;
        if (best_start !== 6'd3 || best_len !== 7'd3 || delay_out !== 6'd4 || fail !== 1'b0) begin
            errors++;
            $display("FAIL tie_result: start=%0d len=%0d delay=%0d fail=%b required 3 3 4 0",
                     best_start, best_len, delay_out, fail);
        end
    endtask

    task automatic test_top_edge;
        int cyc, pul, fu;
        logic [DW-1:0] fd;
        logic b;
        run_scan(range_mask(30, 32) | range_mask(0, 0), -1, cyc, pul, fu, fd, b);
        checks++;
        if (best_start !== 6'd30 || best_len !== 7'd3 || delay_out !== 6'd31 || done !== 1'b1) begin
            errors++;
            $display("FAIL edge_result: start=%0d len=%0d delay=%0d done=%b required 30 3 31 1",
                     best_start, best_len, delay_out, done);
        end
    endtask

    task automatic test_no_match;
        int cyc, pul, fu;
        logic [DW-1:0] fd;
        logic b;
        run_scan(64'd0, -1, cyc, pul, fu, fd, b);
        checks++;
        if (fail !== 1'b1 || done !== 1'b1 || delay_out !== 6'd0 || best_len !== 7'd0) begin
            errors++;
            $display("FAIL nomatch_result: fail=%b done=%b delay=%0d len=%0d required 1 1 0 0",
                     fail, done, delay_out, best_len);
        end
        checks++;
        if (delay_update !== 1'b1 || pul != MAXD + 2) begin
            errors++;
            $display("FAIL nomatch_update: upd=%b pulses=%0d required 1 %0d",
                     delay_update, pul, MAXD + 2);
        end
    endtask

    task automatic test_slow_beats;
        int cyc, pul, fu;
        logic [DW-1:0] fd;
        logic b;
        slow_beats = 1'b1;
        run_scan(range_mask(10, 14), 200, cyc, pul, fu, fd, b);
        slow_beats = 1'b0;
        checks++;
        if (cyc < (MAXD + 1) * 36 + 2 || cyc > (MAXD + 1) * 38 + 2) begin
            errors++;
            $display("FAIL slow_timing: cycles=%0d required %0d..%0d",
                     cyc, (MAXD + 1) * 36 + 2, (MAXD + 1) * 38 + 2);
        end
        checks++;
        if (best_start !== 6'd10 || best_len !== 7'd5 || delay_out !== 6'd12 ||
            fail !== 1'b0 || done !== 1'b1 || pul != MAXD + 2) begin
            errors++;
            $display("FAIL slow_result: start=%0d len=%0d delay=%0d fail=%b done=%b pulses=%0d required 10 5 12 0 1 %0d",
                     best_start, best_len, delay_out, fail, done, pul, MAXD + 2);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_scan();
        test_main_window();
        test_tie();
        test_top_edge();
        test_no_match();
        test_slow_beats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
